hex_word_display: RTL and testbench

HEX_WORD_DISPLAY -- requirements
Module: hex_word_display

---
 rtl/hex_display_pkg.sv | 21 ++
 rtl/hex_glyph_rom.sv | 37 +++
 rtl/hex_word_display.sv | 175 +++++++++++++++++
 tb/tb_hex_word_display.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared colours, glyph geometry and types for the hex word display
package hex_display_pkg;

  localparam logic [7:0] DIGIT_COLOR = 8'hFF;
  localparam logic [7:0] HL_FG_COLOR = 8'h1C;
  localparam logic [7:0] HL_BG_COLOR = 8'hE0;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  typedef logic [GLYPH_W-1:0]         glyph_row_t;
  typedef logic [3:0]                 nibble_t;
  typedef logic [$clog2(GLYPH_H)-1:0] glyph_row_idx_t;
  typedef logic [$clog2(GLYPH_W)-1:0] glyph_col_idx_t;

  // Column 0 is the leftmost pixel, held in the row's MSB.
  function automatic logic glyph_bit(input glyph_row_t bits, input glyph_col_idx_t col);
    return bits[glyph_col_idx_t'(GLYPH_W - 1) - col];
  endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// rtl/hex_glyph_rom.sv - combinational 8x16 bitmap font for hex digits 0-F
module hex_glyph_rom
  import hex_display_pkg::*;
(
  input  nibble_t        digit,
  input  glyph_row_idx_t row,
  output glyph_row_t     bits
);

  logic [GLYPH_W*GLYPH_H-1:0] glyph;

  // Each constant is 16 rows of 8 pixels, top row in the most significant byte.
  always_comb begin
    glyph = '0;
    case (digit)
      4'h0: glyph = 128'h0000_7E66_6666_6666_6666_6666_667E_0000;
      4'h1: glyph = 128'h0000_1838_1818_1818_1818_1818_187E_0000;
      4'h2: glyph = 128'h0000_7E06_0606_067E_6060_6060_607E_0000;
      4'h3: glyph = 128'h0000_7E06_0606_067E_0606_0606_067E_0000;
      4'h4: glyph = 128'h0000_6666_6666_667E_0606_0606_0606_0000;
      4'h5: glyph = 128'h0000_7E60_6060_607E_0606_0606_067E_0000;
      4'h6: glyph = 128'h0000_7E60_6060_607E_6666_6666_667E_0000;
      4'h7: glyph = 128'h0000_7E06_0606_0606_0606_0606_0606_0000;
      4'h8: glyph = 128'h0000_7E66_6666_667E_6666_6666_667E_0000;
      4'h9: glyph = 128'h0000_7E66_6666_667E_0606_0606_067E_0000;
      4'hA: glyph = 128'h0000_183C_6666_667E_6666_6666_6666_0000;
      4'hB: glyph = 128'h0000_7C66_6666_667C_6666_6666_667C_0000;
      4'hC: glyph = 128'h0000_7E60_6060_6060_6060_6060_607E_0000;
      4'hD: glyph = 128'h0000_786C_6666_6666_6666_6666_6C78_0000;
      4'hE: glyph = 128'h0000_7E60_6060_607C_6060_6060_607E_0000;
      4'hF: glyph = 128'h0000_7E60_6060_607C_6060_6060_6060_0000;
      default: glyph = '0;
    endcase
    bits = glyph_row_t'(glyph >> (GLYPH_W * (GLYPH_H - 1 - int'(row))));
  end

endmodule

// File: rtl/hex_word_display.sv
// rtl/hex_word_display.sv - three-stage VGA overlay rendering a word memory as hex digits
module hex_word_display
  import hex_display_pkg::*;
#(
  parameter int  DATA_WIDTH     = 16,
  parameter int  WORDS_PER_LINE = 4,
  parameter int  LINES          = 12,
  parameter int  SCALE          = 2,
  parameter int  WORD_GAP       = 16,
  parameter int  HEX_START_X    = 0,
  parameter int  HEX_START_Y    = 0,
  parameter bit  LZ_SUPPRESS    = 1'b0,
  parameter int  BLINK_FRAMES   = 30,
  localparam int WORDS          = WORDS_PER_LINE * LINES,
  localparam int ADDR_W         = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  startOfFrame,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  hl_en,
  input  logic [ADDR_W-1:0]     hl_addr,
  output logic                  drawingRequest,
  output logic [7:0]            RGBout
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int NIB_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int DIGIT_W = GLYPH_W * SCALE;
  localparam int DIGIT_H = GLYPH_H * SCALE;
  localparam int PITCH   = NIBBLES * DIGIT_W + WORD_GAP;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0] START_X_L = 10'(HEX_START_X);
  localparam logic [9:0] START_Y_L = 10'(HEX_START_Y);
  localparam logic [9:0] PITCH_L   = 10'(PITCH);
  localparam logic [9:0] CELLS_W_L = 10'(NIBBLES * DIGIT_W);
  localparam logic [9:0] DIGIT_W_L = 10'(DIGIT_W);
  localparam logic [9:0] DIGIT_H_L = 10'(DIGIT_H);
  localparam logic [9:0] SCALE_L   = 10'(SCALE);
  localparam logic [9:0] WPL_L     = 10'(WORDS_PER_LINE);
  localparam logic [9:0] LINES_L   = 10'(LINES);
  localparam logic [ADDR_W:0] WORDS_L = (ADDR_W + 1)'(WORDS);

  // Blink timebase
  logic [FC_W-1:0] frame_cnt;
  logic            blink_phase;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Stage 0: locate the pixel. The offset is only taken once the pixel is known
  // to be at or beyond the region origin, so it can never wrap back inside.
  logic              in_x, in_y, in_region, in_gap, in_cell, hl_hit;
  logic [9:0]        rel_x, rel_y, col, line, x_in_word, y_in_line;
  logic [ADDR_W-1:0] word_addr;

  always_comb begin
    in_x      = pixel_x >= START_X_L;
    in_y      = pixel_y >= START_Y_L;
    rel_x     = in_x ? (pixel_x - START_X_L) : '0;
    rel_y     = in_y ? (pixel_y - START_Y_L) : '0;
    col       = rel_x / PITCH_L;
    x_in_word = rel_x % PITCH_L;
    line      = rel_y / DIGIT_H_L;
    y_in_line = rel_y % DIGIT_H_L;
    in_region = in_x && in_y && (col < WPL_L) && (line < LINES_L);
    in_gap    = x_in_word >= CELLS_W_L;
    in_cell   = in_region && !in_gap;
    word_addr = ADDR_W'(line * WPL_L + col);
    hl_hit    = in_cell && hl_en && blink_phase &&
                ({1'b0, hl_addr} < WORDS_L) && (hl_addr == word_addr);
  end

  logic             s0_cell, s0_hl;
  logic [NIB_W-1:0] s0_nib;
  glyph_col_idx_t   s0_gcol;
  glyph_row_idx_t   s0_grow;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_addr <= '0;
      s0_cell <= 1'b0;
      s0_hl   <= 1'b0;
      s0_nib  <= '0;
      s0_gcol <= '0;
      s0_grow <= '0;
    end else begin
      if (in_cell) begin
        rd_addr <= word_addr;
      end
      s0_cell <= in_cell;
      s0_hl   <= hl_hit;
      s0_nib  <= NIB_W'(x_in_word / DIGIT_W_L);
      s0_gcol <= glyph_col_idx_t'((x_in_word % DIGIT_W_L) / SCALE_L);
      s0_grow <= glyph_row_idx_t'(y_in_line / SCALE_L);
    end
  end

  // Stage 1: rd_data is valid for the address registered above.
  // 'upper' keeps the selected nibble and everything more significant,
  // so it is zero exactly when this nibble is a leading zero.
  logic [DATA_WIDTH-1:0] upper;
  nibble_t               digit;
  logic                  last_nib, lz_blank;
  glyph_row_t            row_bits;

  always_comb begin
    upper    = rd_data >> (4 * (NIBBLES - 1 - int'(s0_nib)));
    digit    = nibble_t'(upper);
    last_nib = (int'(s0_nib) == NIBBLES - 1);
    lz_blank = LZ_SUPPRESS && !last_nib && (upper == '0);
  end

  hex_glyph_rom u_glyph_rom (
    .digit (digit),
    .row   (s0_grow),
    .bits  (row_bits)
  );

  logic s1_cell, s1_bit, s1_hl;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_cell <= 1'b0;
      s1_bit  <= 1'b0;
      s1_hl   <= 1'b0;
    end else begin
      s1_cell <= s0_cell;
      s1_bit  <= s0_cell && !lz_blank && glyph_bit(row_bits, s0_gcol);
      s1_hl   <= s0_hl;
    end
  end

  // Stage 2: colour
  logic       pix_draw;
  logic [7:0] pix_color;

  always_comb begin
    pix_draw  = s1_cell && (s1_bit || s1_hl);
    pix_color = 8'h00;
    if (s1_cell) begin
      if (s1_hl) begin
        pix_color = s1_bit ? HL_FG_COLOR : HL_BG_COLOR;
      end else if (s1_bit) begin
        pix_color = DIGIT_COLOR;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
    end else begin
      drawingRequest <= pix_draw;
      RGBout         <= pix_color;
    end
  end

endmodule

// File: tb/tb_hex_word_display.sv
// tb/tb_hex_word_display.sv - directed-vector bench for hex_word_display
module tb_hex_word_display;

  localparam logic [7:0] C_DIGIT = 8'hFF;
  localparam logic [7:0] C_HL_FG = 8'h1C;
  localparam logic [7:0] C_HL_BG = 8'hE0;

  logic       clk = 1'b0;
  logic       resetN, startOfFrame, hl_en;
  logic [5:0] hl_addr;
  logic [9:0] pixel_x, pixel_y;

  logic [5:0]  rd_addr_a, rd_addr_b, rd_addr_c;
  logic [15:0] rd_data_a, rd_data_b;
  logic [31:0] rd_data_c;
  logic        dr_a, dr_b, dr_c;
  logic [7:0]  rgb_a, rgb_b, rgb_c;

  logic [15:0] mem_a [48];
  logic [15:0] mem_b [48];
  logic [31:0] mem_c [48];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rd_data_a = mem_a[rd_addr_a];
  assign rd_data_b = mem_b[rd_addr_b];
  assign rd_data_c = mem_c[rd_addr_c];

  hex_word_display #(.BLINK_FRAMES(2)) dut_a (
    .clk(clk), .resetN(resetN), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .startOfFrame(startOfFrame), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .hl_en(hl_en), .hl_addr(hl_addr), .drawingRequest(dr_a), .RGBout(rgb_a)
  );

  hex_word_display #(.LZ_SUPPRESS(1'b1)) dut_b (
    .clk(clk), .resetN(resetN), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .startOfFrame(startOfFrame), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .hl_en(1'b0), .hl_addr(6'd0), .drawingRequest(dr_b), .RGBout(rgb_b)
  );

  hex_word_display #(.DATA_WIDTH(32)) dut_c (
    .clk(clk), .resetN(resetN), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .startOfFrame(startOfFrame), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .hl_en(1'b0), .hl_addr(6'd0), .drawingRequest(dr_c), .RGBout(rgb_c)
  );

  task automatic settle(input int x, input int y);
    @(negedge clk);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_sof(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) startOfFrame = 1'b1;
      @(negedge clk) startOfFrame = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetN = 1'b0; startOfFrame = 1'b0; hl_en = 1'b0; hl_addr = 6'd0;
    pixel_x = 10'd6; pixel_y = 10'd8;
    repeat (3) @(negedge clk);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL reset_dr_a got %b want 0", dr_a); end
    n_vec++; if (rgb_a !== 8'h00) begin n_err++; $display("FAIL reset_rgb_a got %h want 00", rgb_a); end
    n_vec++; if (rd_addr_a !== 6'd0) begin n_err++; $display("FAIL reset_addr_a got %0d want 0", rd_addr_a); end
    n_vec++; if (dr_b !== 1'b0) begin n_err++; $display("FAIL reset_dr_b got %b want 0", dr_b); end
    n_vec++; if (dr_c !== 1'b0) begin n_err++; $display("FAIL reset_dr_c got %b want 0", dr_c); end
    resetN = 1'b1;
  endtask

  // Back-to-back pixels across digits '1' and '2' of 16'h1234, glyph row 4.
  task automatic test_digit_row;
    logic [7:0] rb;
    logic       e;
    int         x;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (i >= 3) begin
        x  = i - 3;
        rb = (x < 16) ? 8'h18 : 8'h06;
        e  = rb[7 - (x % 16) / 2];
        n_vec++;
        if (dr_a !== e || rgb_a !== (e ? C_DIGIT : 8'h00)) begin
          n_err++; $display("FAIL row_x%0d got dr=%b rgb=%h want dr=%b", x, dr_a, rgb_a, e);
        end
      end
      if (i < 32) begin pixel_x = 10'(i); pixel_y = 10'd8; end
    end
    n_vec++; if (rd_addr_a !== 6'd0) begin n_err++; $display("FAIL row_addr got %0d want 0", rd_addr_a); end
  endtask

  task automatic test_region;
    settle(80, 0);
    n_vec++; if (rd_addr_a !== 6'd1) begin n_err++; $display("FAIL col1_addr got %0d want 1", rd_addr_a); end
    settle(70, 8);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL gap_dr got %b want 0", dr_a); end
    n_vec++; if (rd_addr_a !== 6'd1) begin n_err++; $display("FAIL gap_hold got %0d want 1", rd_addr_a); end
    settle(0, 32);
    n_vec++; if (rd_addr_a !== 6'd4) begin n_err++; $display("FAIL line1_addr got %0d want 4", rd_addr_a); end
    settle(326, 8);
    n_vec++; if (dr_a !== 1'b0 || rgb_a !== 8'h00) begin n_err++; $display("FAIL col4_out got dr=%b rgb=%h want 0", dr_a, rgb_a); end
    n_vec++; if (rd_addr_a !== 6'd4) begin n_err++; $display("FAIL col4_hold got %0d want 4", rd_addr_a); end
    settle(6, 392);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL line12_out got %b want 0", dr_a); end
    settle(6, 8);
    n_vec++; if (dr_a !== 1'b1 || rgb_a !== C_DIGIT) begin n_err++; $display("FAIL w0_on got dr=%b rgb=%h want 1/ff", dr_a, rgb_a); end
  endtask

  // 16'h0040 at word 0 and 16'h0000 at word 1, pixel column 2 of each cell, glyph row 4.
  task automatic test_lz;
    int  xs [8]  = '{2, 18, 34, 50, 82, 98, 114, 130};
    bit  exp [8] = '{0, 0, 1, 1, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      settle(xs[i], 8);
      n_vec++;
      if (dr_b !== exp[i] || rgb_b !== (exp[i] ? C_DIGIT : 8'h00)) begin
        n_err++; $display("FAIL lz_x%0d got dr=%b rgb=%h want dr=%b", xs[i], dr_b, rgb_b, exp[i]);
      end
    end
  endtask

  function automatic logic [7:0] wide_byte(input logic [3:0] d, input bit bottom);
    case (d)
      4'hA:    return bottom ? 8'h66 : 8'h18;
      4'hB:    return 8'h7C;
      4'hD:    return 8'h78;
      4'hE:    return 8'h7E;
      default: return bottom ? 8'h60 : 8'h7E;
    endcase
  endfunction

  // 32'hDEADBEEF at glyph rows 2 and 13, which tell all five letters apart.
  task automatic test_wide;
    logic [3:0] dg [8] = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF};
    logic [7:0] rb;
    logic       e;
    int         x;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 131; i++) begin
        @(negedge clk);
        if (i >= 3) begin
          x  = i - 3;
          rb = wide_byte(dg[x / 16], r == 1);
          e  = rb[7 - (x % 16) / 2];
          n_vec++;
          if (dr_c !== e || rgb_c !== (e ? C_DIGIT : 8'h00)) begin
            n_err++; $display("FAIL wide_r%0d_x%0d got dr=%b rgb=%h want dr=%b", r, x, dr_c, rgb_c, e);
          end
        end
        if (i < 128) begin pixel_x = 10'(i); pixel_y = (r == 1) ? 10'd26 : 10'd4; end
      end
    end
    settle(144, 0);
    n_vec++; if (rd_addr_c !== 6'd1) begin n_err++; $display("FAIL wide_col1 got %0d want 1", rd_addr_c); end
    settle(0, 32);
    n_vec++; if (rd_addr_c !== 6'd4) begin n_err++; $display("FAIL wide_line1 got %0d want 4", rd_addr_c); end
    settle(130, 4);
    n_vec++; if (dr_c !== 1'b0) begin n_err++; $display("FAIL wide_gap got %b want 0", dr_c); end
    n_vec++; if (rd_addr_c !== 6'd4) begin n_err++; $display("FAIL wide_gap_hold got %0d want 4", rd_addr_c); end
  endtask

  task automatic test_blink;
    hl_en = 1'b1; hl_addr = 6'd5;
    settle(80, 40);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL hl_phase0 got %b want 0", dr_a); end
    pulse_sof(2);
    settle(80, 40);
    n_vec++; if (dr_a !== 1'b1 || rgb_a !== C_HL_BG) begin n_err++; $display("FAIL hl_bg got dr=%b rgb=%h want 1/%h", dr_a, rgb_a, C_HL_BG); end
    settle(86, 40);
    n_vec++; if (dr_a !== 1'b1 || rgb_a !== C_HL_FG) begin n_err++; $display("FAIL hl_fg got dr=%b rgb=%h want 1/%h", dr_a, rgb_a, C_HL_FG); end
    settle(0, 40);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL hl_word4 got %b want 0", dr_a); end
    settle(150, 40);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL hl_gap got %b want 0", dr_a); end
    hl_addr = 6'd60;
    settle(80, 40);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL hl_range got %b want 0", dr_a); end
    hl_addr = 6'd5; hl_en = 1'b0;
    settle(80, 40);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL hl_disabled got %b want 0", dr_a); end
    hl_en = 1'b1;
    pulse_sof(2);
    settle(80, 40);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL hl_off_bg got %b want 0", dr_a); end
    settle(86, 40);
    n_vec++; if (dr_a !== 1'b1 || rgb_a !== C_DIGIT) begin n_err++; $display("FAIL hl_off_fg got dr=%b rgb=%h want 1/ff", dr_a, rgb_a); end
  endtask

  // Leaves the blink counter at 1 with phase 1, then resets mid-cycle.
  task automatic test_reset_mid;
    pulse_sof(3);
    settle(86, 40);
    n_vec++; if (dr_a !== 1'b1 || rgb_a !== C_HL_FG) begin n_err++; $display("FAIL pre_rst got dr=%b rgb=%h want 1/%h", dr_a, rgb_a, C_HL_FG); end
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    n_vec++; if (dr_a !== 1'b0 || rgb_a !== 8'h00) begin n_err++; $display("FAIL async_rst got dr=%b rgb=%h want 0", dr_a, rgb_a); end
    n_vec++; if (rd_addr_a !== 6'd0) begin n_err++; $display("FAIL async_rst_addr got %0d want 0", rd_addr_a); end
    @(negedge clk) resetN = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL resume_early got %b want 0", dr_a); end
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (dr_a !== 1'b1 || rgb_a !== C_DIGIT) begin n_err++; $display("FAIL resume got dr=%b rgb=%h want 1/ff", dr_a, rgb_a); end
    pulse_sof(1);
    settle(80, 40);
    n_vec++; if (dr_a !== 1'b0) begin n_err++; $display("FAIL rst_cnt got %b want 0", dr_a); end
    pulse_sof(1);
    settle(80, 40);
    n_vec++; if (dr_a !== 1'b1 || rgb_a !== C_HL_BG) begin n_err++; $display("FAIL rst_cnt_wrap got dr=%b rgb=%h want 1/%h", dr_a, rgb_a, C_HL_BG); end
  endtask

  initial begin
    for (int i = 0; i < 48; i++) begin
      mem_a[i] = 16'h0000; mem_b[i] = 16'h0000; mem_c[i] = 32'h0;
    end
    mem_a[0] = 16'h1234; mem_a[4] = 16'h1111; mem_a[5] = 16'h1234;
    mem_b[0] = 16'h0040; mem_b[1] = 16'h0000;
    mem_c[0] = 32'hDEADBEEF;

    test_reset;
    test_digit_row;
    test_region;
    test_lz;
    test_wide;
    test_blink;
    test_reset_mid;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", n_vec);
    $fatal(1);
  end

endmodule
